regs_wb_issuer: RTL and testbench

Controller-side transmitter for the register-file write interface.
- Collects writeback requests from execute/load stages through a valid/ready handshake and buffers them in a small in-order FIFO.
- Issues one RegfileWriteType beat per cycle with a single-cycle sync strobe.
- Provides combinational forwarding of pending (not-yet-committed) writes so the controller's operand read never sees stale register data.

---
 rtl/top_level_types.sv | 25 ++
 rtl/regs_wb_fifo.sv | 61 ++++++
 rtl/regs_wb_issuer.sv | 131 +++++++++++++
 tb/tb_regs_wb_issuer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/top_level_types.sv
// Shared register-file write types and sizing constants for the controller writeback path.
// REGS_WB_COALESCE_EN (optional build macro) is consumed by regs_wb_issuer, not here.
package top_level_types;

    localparam int REGS_WB_DEPTH = 4;
    localparam int REGS_ADDR_W   = 5;
    localparam int REGS_DATA_W   = 32;

    typedef struct packed {
        logic [REGS_ADDR_W-1:0] dst;
        logic [REGS_DATA_W-1:0] dstdata;
    } RegfileWriteType;

    typedef struct packed {
        logic [REGS_ADDR_W-1:0] dst;
        logic [REGS_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ACTIVE,
        OCC_FULL
    } occ_state_t;

endpackage

// File: rtl/regs_wb_fifo.sv
// In-order FIFO exposing every entry oldest-first; push/pop take effect at the next edge.
// No internal backpressure: caller never pushes when full or pops when empty; clr_i beats push/pop.
module regs_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_i,
    input  logic                        push_i,
    input  logic                        tail_upd_i,
    input  logic [WIDTH-1:0]            dat_i,
    input  logic                        pop_i,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic [DEPTH-1:0][WIDTH-1:0] ent_o,
    output logic [DEPTH-1:0]            ent_vld_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]               rd_ptr_q;
    logic [PW-1:0]               wr_ptr_q;
    logic [PW:0]                 count_q;
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '0;
        end else if (clr_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= dat_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            // Tail overwrite targets the most recently written slot.
            if (tail_upd_i) begin
                mem_q[wr_ptr_q - PW'(1)] <= dat_i;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_o[i]     = mem_q[rd_ptr_q + PW'(i)];
            ent_vld_o[i] = ((PW+1)'(i) < count_q);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/regs_wb_issuer.sv
// Writeback issuer: buffers requests, emits one regfile beat per cycle (sync one cycle after pop), forwards pending data.
// wb_ready drops only when full or flushing (never pop-dependent); REGS_WB_COALESCE_EN merges same-dst pushes into the tail.
module regs_wb_issuer
    import top_level_types::*;
#(
    parameter int DEPTH  = REGS_WB_DEPTH,
    parameter int ADDR_W = REGS_ADDR_W,
    parameter int DATA_W = REGS_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [ADDR_W-1:0]        wb_dst,
    input  logic [DATA_W-1:0]        wb_data,
    output RegfileWriteType          CtlToRegs_port,
    output logic                     CtlToRegs_port_sync,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_pending,
    output logic [DATA_W-1:0]        rd_fwd_data,
    output logic [$clog2(DEPTH):0]   wb_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    occ_state_t            occ_q;
    RegfileWriteType       beat_q;
    logic                  sync_q;
    wb_entry_t [DEPTH-1:0] ent;
    logic [DEPTH-1:0]      ent_vld;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  pop_en;
    logic                  push_en;
    logic                  accept;
    logic                  coal_hit;
    wb_entry_t             push_ent;

    assign push_ent = '{dst: wb_dst, data: wb_data};
    assign pop_en   = !flush && (occ_q != OCC_EMPTY);

`ifdef REGS_WB_COALESCE_EN
    localparam int PW = $clog2(DEPTH);
    wb_entry_t tail_ent;
    logic      tail_live;

    // A lone entry being popped this cycle is already gone, so it cannot absorb the push.
    assign tail_ent  = ent[PW'(count - CW'(1))];
    assign tail_live = (count != '0) && !(pop_en && (count == CW'(1)));
    assign coal_hit  = tail_live && (tail_ent.dst == wb_dst);
`else
    assign coal_hit = 1'b0;
`endif

    assign wb_ready  = !flush && ((occ_q != OCC_FULL) || coal_hit);
    assign accept    = wb_valid && wb_ready;
    assign push_en   = accept && (wb_dst != '0) && !coal_hit;
    assign count_nxt = flush ? '0 : (count + CW'(push_en) - CW'(pop_en));

    regs_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (flush),
        .push_i     (push_en),
        .tail_upd_i (accept && coal_hit),
        .dat_i      (push_ent),
        .pop_i      (pop_en),
        .count_o    (count),
        .ent_o      (ent),
        .ent_vld_o  (ent_vld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q  <= OCC_EMPTY;
            beat_q <= '0;
            sync_q <= 1'b0;
        end else begin
            sync_q <= pop_en;
            if (pop_en) begin
                beat_q <= '{dst: ent[0].dst, dstdata: ent[0].data};
            end
            if (flush) begin
                occ_q <= OCC_EMPTY;
            end else begin
                case (occ_q)
                    OCC_EMPTY: begin
                        if (push_en) occ_q <= OCC_ACTIVE;
                    end
                    OCC_ACTIVE: begin
                        if (count_nxt == CW'(DEPTH)) occ_q <= OCC_FULL;
                        else if (count_nxt == '0)    occ_q <= OCC_EMPTY;
                    end
                    OCC_FULL: begin
                        if (pop_en) occ_q <= OCC_ACTIVE;
                    end
                    default: occ_q <= OCC_EMPTY;
                endcase
            end
        end
    end

    // The issued beat is oldest; scanning it first lets younger FIFO hits override it.
    always_comb begin
        rd_pending  = 1'b0;
        rd_fwd_data = '0;
        if (sync_q && (beat_q.dst == rd_addr)) begin
            rd_pending  = 1'b1;
            rd_fwd_data = beat_q.dstdata;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent[i].dst == rd_addr)) begin
                rd_pending  = 1'b1;
                rd_fwd_data = ent[i].data;
            end
        end
        if (rd_addr == '0) begin
            rd_pending  = 1'b0;
            rd_fwd_data = '0;
        end
    end

    assign CtlToRegs_port      = beat_q;
    assign CtlToRegs_port_sync = sync_q;
    assign wb_count            = count;

endmodule

// File: tb/tb_regs_wb_issuer.sv
// Bench for regs_wb_issuer: scoreboard of expected regfile beats plus per-scenario timing checks.
module tb_regs_wb_issuer;
    import top_level_types::*;

    logic            clk      = 1'b0;
    logic            rst      = 1'b1;
    logic            flush    = 1'b0;
    logic            wb_valid = 1'b0;
    logic            wb_ready;
    logic [4:0]      wb_dst   = '0;
    logic [31:0]     wb_data  = '0;
    RegfileWriteType port;
    logic            sync;
    logic [4:0]      rd_addr  = '0;
    logic            rd_pending;
    logic [31:0]     rd_fwd_data;
    logic [2:0]      wb_count;

    int total  = 0;
    int passed = 0;
    RegfileWriteType exp_q[$];

    always #5 clk = ~clk;

    regs_wb_issuer dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .wb_valid            (wb_valid),
        .wb_ready            (wb_ready),
        .wb_dst              (wb_dst),
        .wb_data             (wb_data),
        .CtlToRegs_port      (port),
        .CtlToRegs_port_sync (sync),
        .rd_addr             (rd_addr),
        .rd_pending          (rd_pending),
        .rd_fwd_data         (rd_fwd_data),
        .wb_count            (wb_count)
    );

    // Every sync pulse must deliver the oldest outstanding expected beat.
    always @(negedge clk) begin : monitor
        RegfileWriteType e;
        if (rst && sync) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL beat_order: unexpected beat {%0d,%h}, required no beat", port.dst, port.dstdata);
            end else begin
                e = exp_q.pop_front();
                if (port !== e)
                    $display("FAIL beat_order: got {%0d,%h}, required {%0d,%h}", port.dst, port.dstdata, e.dst, e.dstdata);
                else
                    passed++;
            end
        end
    end

    task automatic drive(input bit v, input logic [4:0] d, input logic [31:0] x);
        wb_valid = v;
        wb_dst   = d;
        wb_data  = x;
        if (v && !flush && (d != 5'd0))
            exp_q.push_back('{dst: d, dstdata: x});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        total++; if (sync !== 1'b0) $display("FAIL rst_sync: got %b, required 0", sync); else passed++;
        total++; if (port !== '0) $display("FAIL rst_port: got {%0d,%h}, required {0,0}", port.dst, port.dstdata); else passed++;
        total++; if (wb_count !== 3'd0) $display("FAIL rst_count: got %0d, required 0", wb_count); else passed++;
        total++; if (rd_pending !== 1'b0 || rd_fwd_data !== 32'd0)
            $display("FAIL rst_fwd: got pend=%b data=%h, required 0/0", rd_pending, rd_fwd_data); else passed++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (wb_ready !== 1'b1) $display("FAIL rst_ready: got %b, required 1", wb_ready); else passed++;
    endtask

    task automatic test_single();
        next_cycle();
        drive(1, 5'd5, 32'hDEADBEEF);
        rd_addr = 5'd5;
        @(negedge clk);
        total++; if (wb_ready !== 1'b1) $display("FAIL single_ready: got %b, required 1", wb_ready); else passed++;
        next_cycle();
        drive(0, 5'd0, 32'd0);
        @(negedge clk);
        total++; if (wb_count !== 3'd1 || sync !== 1'b0)
            $display("FAIL single_queued: got count=%0d sync=%b, required 1/0", wb_count, sync); else passed++;
        total++; if (rd_pending !== 1'b1 || rd_fwd_data !== 32'hDEADBEEF)
            $display("FAIL single_fwd_fifo: got pend=%b data=%h, required 1/deadbeef", rd_pending, rd_fwd_data); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (sync !== 1'b1 || port.dst !== 5'd5 || port.dstdata !== 32'hDEADBEEF || wb_count !== 3'd0)
            $display("FAIL single_issue: got sync=%b {%0d,%h} count=%0d, required 1 {5,deadbeef} 0",
                     sync, port.dst, port.dstdata, wb_count); else passed++;
        total++; if (rd_pending !== 1'b1 || rd_fwd_data !== 32'hDEADBEEF)
            $display("FAIL single_fwd_outreg: got pend=%b data=%h, required 1/deadbeef", rd_pending, rd_fwd_data); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (sync !== 1'b0 || port.dst !== 5'd5 || port.dstdata !== 32'hDEADBEEF)
            $display("FAIL single_hold: got sync=%b {%0d,%h}, required 0 {5,deadbeef}", sync, port.dst, port.dstdata); else passed++;
        total++; if (rd_pending !== 1'b0 || rd_fwd_data !== 32'd0)
            $display("FAIL single_fwd_clear: got pend=%b data=%h, required 0/0", rd_pending, rd_fwd_data); else passed++;
    endtask

    task automatic test_back_to_back();
        bit       exp_sync [7] = '{0, 0, 1, 1, 1, 1, 0};
        bit [2:0] exp_cnt  [7] = '{0, 1, 1, 1, 1, 0, 0};
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            if (k < 4) drive(1, 5'(k + 10), 32'h1111_1111 * (k + 1));
            else       drive(0, 5'd0, 32'd0);
            @(negedge clk);
            if (k < 4) begin
                total++; if (wb_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b, required 1", k, wb_ready); else passed++;
            end
            total++; if (sync !== exp_sync[k] || wb_count !== exp_cnt[k])
                $display("FAIL b2b_timing[%0d]: got sync=%b count=%0d, required %b/%0d", k, sync, wb_count, exp_sync[k], exp_cnt[k]);
            else passed++;
        end
    endtask

    task automatic test_forward();
        bit        exp_pend [5] = '{0, 1, 1, 1, 0};
        bit [31:0] exp_dat  [5] = '{0, 1, 2, 2, 0};
        rd_addr = 5'd7;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            if (k == 0)      drive(1, 5'd7, 32'd1);
            else if (k == 1) drive(1, 5'd7, 32'd2);
            else             drive(0, 5'd0, 32'd0);
            @(negedge clk);
            total++; if (rd_pending !== exp_pend[k] || rd_fwd_data !== exp_dat[k])
                $display("FAIL fwd_youngest[%0d]: got pend=%b data=%h, required %b/%h", k, rd_pending, rd_fwd_data, exp_pend[k], exp_dat[k]);
            else passed++;
            if (k == 2) begin
                rd_addr = 5'd9;
                #1;
                total++; if (rd_pending !== 1'b0 || rd_fwd_data !== 32'd0)
                    $display("FAIL fwd_nomatch: got pend=%b data=%h, required 0/0", rd_pending, rd_fwd_data); else passed++;
                rd_addr = 5'd7;
            end
        end
    endtask

    task automatic test_x0();
        rd_addr = 5'd0;
        next_cycle();
        drive(1, 5'd0, 32'h1234);
        @(negedge clk);
        total++; if (wb_ready !== 1'b1) $display("FAIL x0_ready: got %b, required 1", wb_ready); else passed++;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            drive(0, 5'd0, 32'd0);
            @(negedge clk);
            total++; if (wb_count !== 3'd0 || sync !== 1'b0 || rd_pending !== 1'b0 || rd_fwd_data !== 32'd0)
                $display("FAIL x0_drop[%0d]: got count=%0d sync=%b pend=%b data=%h, required 0/0/0/0",
                         k, wb_count, sync, rd_pending, rd_fwd_data);
            else passed++;
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            drive(1, 5'(k + 1), 32'hA000_0000 + k);
        end
        next_cycle();
        flush = 1'b1;
        drive(1, 5'd4, 32'hA000_0004);
        @(negedge clk);
        total++; if (wb_ready !== 1'b0) $display("FAIL flush_ready: got %b, required 0", wb_ready); else passed++;
        total++; if (wb_count !== 3'd1) $display("FAIL flush_precount: got %0d, required 1", wb_count); else passed++;
        @(posedge clk);
        exp_q.delete();
        #1;
        flush = 1'b0;
        drive(0, 5'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (wb_count !== 3'd0 || sync !== 1'b0)
                $display("FAIL flush_drop[%0d]: got count=%0d sync=%b, required 0/0", k, wb_count, sync); else passed++;
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_burst();
        rd_addr = 5'd2;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            drive(1, 5'(k + 1), 32'hB000_0000 + k);
        end
        @(negedge clk);
        total++; if (sync !== 1'b1 || rd_pending !== 1'b1 || rd_fwd_data !== 32'hB000_0001)
            $display("FAIL rstmid_pre: got sync=%b pend=%b data=%h, required 1/1/b0000001", sync, rd_pending, rd_fwd_data);
        else passed++;
        #2;
        rst = 1'b0;
        exp_q.delete();
        drive(0, 5'd0, 32'd0);
        #1;
        total++; if (sync !== 1'b0 || port !== '0 || wb_count !== 3'd0 || rd_pending !== 1'b0 || rd_fwd_data !== 32'd0)
            $display("FAIL rstmid_async: got sync=%b {%0d,%h} count=%0d pend=%b data=%h, required all 0",
                     sync, port.dst, port.dstdata, wb_count, rd_pending, rd_fwd_data);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++; if (sync !== 1'b0 || wb_count !== 3'd0 || wb_ready !== 1'b1)
                $display("FAIL rstmid_after[%0d]: got sync=%b count=%0d ready=%b, required 0/0/1", k, sync, wb_count, wb_ready);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_forward();
        test_x0();
        test_flush();
        test_reset_mid_burst();
        repeat (3) @(negedge clk);
        total++; if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d beats outstanding, required 0", exp_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
